// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M multiply/divide unit, iterative radix-2 or single-cycle multiply (FAST_MUL).
// Divider datapath is built only when MULDIV_DIV_EN is defined; otherwise funct3 4-7 complete at once with result 0.
module mul_div_unit #(
  parameter bit FAST_MUL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        we_out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0]  f_q, f_d;
  logic [4:0]  rd_q, rd_d, cnt_q, cnt_d;
  logic [31:0] d_q, d_d, res_q, res_d;
  logic [63:0] p_q, p_d;
  logic        ng_q, ng_d, rn_q, rn_d;
  logic        acc, sa, sb, neg_a, neg_b, single;
  logic [31:0] ma, mb, quick;
  logic [63:0] fprod, mstep, step;
  logic [32:0] sum;

  // Operands are held as magnitudes; p holds {acc/rem, multiplier/quotient}.
  function automatic logic [31:0] fin(input logic [2:0] f, input logic ng, input logic rn, input logic [63:0] p);
    logic [63:0] s;
    s = ng ? -p : p;
    if (!f[2]) return f == 3'd0 ? s[31:0] : s[63:32];
    if (f[1]) return rn ? -p[63:32] : p[63:32];
    return s[31:0];
  endfunction

  assign acc   = start && state_q != CALC;
  assign sa    = funct3 == 3'd1 || funct3 == 3'd2 || (funct3[2] && !funct3[0]);
  assign sb    = funct3 == 3'd1 || (funct3[2] && !funct3[0]);
  assign neg_a = sa && op_a[31];
  assign neg_b = sb && op_b[31];
  assign ma    = neg_a ? -op_a : op_a;
  assign mb    = neg_b ? -op_b : op_b;
  assign fprod = {32'b0, ma} * {32'b0, mb};
  assign sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, d_q} : 33'd0);
  assign mstep = {sum, p_q[31:1]};

`ifdef MULDIV_DIV_EN
  logic        dz, ovf;
  logic [33:0] df;
  assign dz     = funct3[2] && op_b == 32'd0;
  assign ovf    = funct3[2] && !funct3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;
  assign single = dz || ovf || (FAST_MUL && !funct3[2]);
  assign quick  = dz ? (funct3[1] ? op_a : 32'hFFFF_FFFF) :
                  ovf ? (funct3[1] ? 32'd0 : 32'h8000_0000) : fin(funct3, neg_a ^ neg_b, neg_a, fprod);
  // Restoring divide: shift remainder left, subtract divisor when it fits.
  assign df     = {1'b0, p_q[63:31]} - {2'b0, d_q};
  assign step   = f_q[2] ? {df[33] ? p_q[62:31] : df[31:0], p_q[30:0], !df[33]} : mstep;
`else
  assign single = funct3[2] || FAST_MUL;
  assign quick  = funct3[2] ? 32'd0 : fin(funct3, neg_a ^ neg_b, neg_a, fprod);
  assign step   = mstep;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == CALC) state_d = cnt_q == 5'd31 ? DONE : CALC;
    else state_d = start ? (single ? DONE : CALC) : IDLE;
  end

  always_comb begin
    busy = state_q == CALC;
    done = state_q == DONE;
`ifdef MULDIV_DIV_EN
    we_out = done && rd_q != 5'd0;
`else
    we_out = done && rd_q != 5'd0 && !f_q[2];
`endif
  end

  always_comb begin
    f_d = f_q;
    rd_d = rd_q;
    d_d = d_q;
    p_d = p_q;
    ng_d = ng_q;
    rn_d = rn_q;
    res_d = res_q;
    cnt_d = cnt_q;
    if (acc) begin
      f_d = funct3;
      rd_d = rd_in;
      ng_d = neg_a ^ neg_b;
      rn_d = neg_a;
      cnt_d = 5'd0;
      d_d = funct3[2] ? mb : ma;
      p_d = {32'b0, funct3[2] ? ma : mb};
      if (single) res_d = quick;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 5'd1;
      p_d = step;
      if (cnt_q == 5'd31) res_d = fin(f_q, ng_q, rn_q, step);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f_q <= '0;
      rd_q <= '0;
      d_q <= '0;
      p_q <= '0;
      ng_q <= 1'b0;
      rn_q <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      f_q <= f_d;
      rd_q <= rd_d;
      d_q <= d_d;
      p_q <= p_d;
      ng_q <= ng_d;
      rn_q <= rn_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end

  assign result = res_q;
  assign rd_out = rd_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit (FAST_MUL=0).
// Divide expectations follow MULDIV_DIV_EN: real results when defined, result 0 / no write otherwise.
module tb_mul_div_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.FAST_MUL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  // Issue one op; lat counts clock edges from the start edge until done is seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output int lat, output logic [31:0] res, output logic we, output logic [4:0] rdo);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result; we = we_out; rdo = rd_out;
  endtask

  task automatic test_reset();
    #2;
    checks += 5;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    if (we_out !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", we_out); end
    if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    if (rd_out !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", rd_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r; logic we; logic [4:0] rdo;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, r, we, rdo);
    checks += 4;
    if (lat !== 33) begin fails++; $display("FAIL mul_latency got %0d want 33", lat); end
    if (r !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result got %h want ffffffeb", r); end
    if (we !== 1'b1) begin fails++; $display("FAIL mul_we got %b want 1", we); end
    if (rdo !== 5'd5) begin fails++; $display("FAIL mul_rd got %0d want 5", rdo); end
  endtask

  task automatic test_mulh();
    logic [2:0]  tf[6];
    logic [31:0] ta[6], tb[6], te[6];
    int lat; logic [31:0] r; logic we; logic [4:0] rdo;
    tf = '{3'd3, 3'd1, 3'd2, 3'd1, 3'd3, 3'd0};
    ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    tb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'd4, 32'd16};
    te = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h2345_6780};
    for (int i = 0; i < 6; i++) begin
      run_op(tf[i], ta[i], tb[i], 5'd1, lat, r, we, rdo);
      checks += 2;
      if (lat !== 33) begin fails++; $display("FAIL mulh_latency[%0d] got %0d want 33", i, lat); end
      if (r !== te[i]) begin fails++; $display("FAIL mulh_result[%0d] got %h want %h", i, r, te[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  tf[9];
    logic [31:0] ta[9], tb[9], te[9];
    int          tl[9];
    int lat; logic [31:0] r; logic we; logic [4:0] rdo;
    tf = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd6};
    ta = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd7};
    tb = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
`ifdef MULDIV_DIV_EN
    te = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd14, 32'd2, 32'h8000_0000, 32'd0, 32'd1};
    tl = '{33, 33, 1, 1, 33, 33, 1, 1, 33};
`else
    te = '{default: 32'd0};
    tl = '{default: 1};
`endif
    for (int i = 0; i < 9; i++) begin
      run_op(tf[i], ta[i], tb[i], 5'd6, lat, r, we, rdo);
      checks += 3;
      if (lat !== tl[i]) begin fails++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, tl[i]); end
      if (r !== te[i]) begin fails++; $display("FAIL div_result[%0d] got %h want %h", i, r, te[i]); end
`ifdef MULDIV_DIV_EN
      if (we !== 1'b1) begin fails++; $display("FAIL div_we[%0d] got %b want 1", i, we); end
`else
      if (we !== 1'b0) begin fails++; $display("FAIL div_we[%0d] got %b want 0", i, we); end
`endif
    end
  endtask

  task automatic test_busy_ignore();
    int nd; logic [31:0] r; logic [4:0] rdo;
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_calc got %b want 1", busy); end
    funct3 = 3'd3; op_a = 32'd100; op_b = 32'd100; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; r = '0; rdo = '0;
    repeat (60) begin
      @(negedge clk);
      if (done) begin nd++; r = result; rdo = rd_out; end
    end
    checks += 3;
    if (nd !== 1) begin fails++; $display("FAIL ignore_done_count got %0d want 1", nd); end
    if (r !== 32'd42) begin fails++; $display("FAIL ignore_result got %h want 2a", r); end
    if (rdo !== 5'd3) begin fails++; $display("FAIL ignore_rd got %0d want 3", rdo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks += 2;
    if (lat !== 33) begin fails++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
    if (result !== 32'd6) begin fails++; $display("FAIL b2b_first_result got %h want 6", result); end
    funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'd2; rd_in = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); end
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks += 3;
    if (lat !== 33) begin fails++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
    if (result !== 32'd1) begin fails++; $display("FAIL b2b_second_result got %h want 1", result); end
    if (rd_out !== 5'd2) begin fails++; $display("FAIL b2b_second_rd got %0d want 2", rd_out); end
    @(negedge clk);
    checks++;
    if (result !== 32'd1 || done !== 1'b0) begin fails++; $display("FAIL b2b_hold got result=%h done=%b want 1 0", result, done); end
  endtask

  task automatic test_rd_zero_and_abort();
    int lat, nd; logic [31:0] r; logic we; logic [4:0] rdo;
    run_op(3'd0, 32'd3, 32'd4, 5'd0, lat, r, we, rdo);
    checks += 3;
    if (lat !== 33) begin fails++; $display("FAIL rd0_latency got %0d want 33", lat); end
    if (r !== 32'd12) begin fails++; $display("FAIL rd0_result got %h want c", r); end
    if (we !== 1'b0) begin fails++; $display("FAIL rd0_we got %b want 0", we); end
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0 || we_out !== 1'b0) begin fails++; $display("FAIL abort_done got done=%b we=%b want 0 0", done, we_out); end
    if (result !== 32'd0) begin fails++; $display("FAIL abort_result got %h want 0", result); end
    if (rd_out !== 5'd0) begin fails++; $display("FAIL abort_rd got %0d want 0", rd_out); end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", nd); end
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL first_edge_accept got busy=%b want 1", busy); end
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks += 3;
    if (lat !== 33) begin fails++; $display("FAIL post_reset_latency got %0d want 33", lat); end
    if (result !== 32'd4) begin fails++; $display("FAIL post_reset_result got %h want 4", result); end
    if (we_out !== 1'b1 || rd_out !== 5'd4) begin fails++; $display("FAIL post_reset_we got we=%b rd=%0d want 1 4", we_out, rd_out); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_busy_ignore();
    test_back_to_back();
    test_rd_zero_and_abort();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
